wb_select_ctrl: RTL
===================

// Module: wb_select_ctrl
// PURPOSE
// - Write-back sequencer: accepts decoded dest/source info per instruction, waits for load data when needed,
//   and drives the 3-bit result select, rd and write enable for the 5:1 write-back mux / register file.
// - Sits between decode and the write-back mux; first step toward a multi-cycle load path.
// PARAMETERS
// - TIMEOUT_CYCLES  16  max cycles waiting for a load response before abort (>=2)
// - CNT_W           32  width of retired-write counter
// PORTS
// - clk              in   1      clock, all state on rising edge
// - rst              in   1      synchronous, active-high reset
// - issue_valid_i    in   1      decoded instruction valid
// - issue_ready_o    out  1      block can accept an instruction this cycle
// - wb_src_i         in   3      source code (wb_src_e)
// - rd_i             in   5      destination register
// - mem_rvalid_i     in   1      load data valid this cycle (data itself goes straight to mux input B)
// - flush_i          in   1      pipeline flush / abort
// - result_sel_o     out  3      mux select (registered)
// - rd_o             out  5      register-file write address (registered)
// - reg_we_o         out  1      register-file write enable, 1-cycle pulse
// - err_o            out  1      1-cycle pulse: illegal code, stray response, or timeout
// - retired_cnt_o    out  CNT_W  count of reg_we_o pulses, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Source codes (= select codes): ALU 000, MEM 001, PC4 011, IMM 010, PCIMM 110. Other codes illegal.
// - Reset: state IDLE; result_sel_o=000, rd_o=0, reg_we_o=0, err_o=0, retired_cnt_o=0, timeout ctr=0.
// - Handshake: accept when issue_valid_i & issue_ready_o. issue_ready_o = (state==IDLE) & ~flush_i.
// - States: IDLE, WAIT_MEM, DRAIN.
// - IDLE, accept non-MEM legal code: next cycle result_sel_o=code, rd_o=rd_i, reg_we_o=(rd_i!=0). Latency 1,
//   one accept per cycle back-to-back.
// - IDLE, accept MEM: latch rd, go WAIT_MEM, clear timeout ctr; reg_we_o=0.
// - WAIT_MEM & mem_rvalid_i: next cycle result_sel_o=001, rd_o=latched rd, reg_we_o=(rd!=0); go IDLE.
//   Next instruction accepted no earlier than the cycle after the rvalid.
// - WAIT_MEM & flush_i & ~mem_rvalid_i: no write; go DRAIN, clear ctr.
// - WAIT_MEM & flush_i & mem_rvalid_i same cycle: flush wins, no write, response consumed -> IDLE.
// - DRAIN: ready low; mem_rvalid_i -> IDLE, no write, no error (expected orphan).
// - Timeout: ctr counts each cycle in WAIT_MEM/DRAIN; cycle ctr==TIMEOUT_CYCLES-1 without rvalid ->
//   err_o pulse next cycle, no write, -> IDLE.
// - Illegal code accepted: result_sel_o=111 (mux yields 0), reg_we_o=0, err_o pulse; stays IDLE.
// - mem_rvalid_i in IDLE: ignored, err_o pulse. Flush in IDLE: nothing accepted, no state change.
// - result_sel_o/rd_o hold last value when reg_we_o=0 (except illegal case above).
// - rd==0 never asserts reg_we_o and does not increment retired_cnt_o.
// - Reset mid-WAIT_MEM/DRAIN: back to IDLE, outstanding response forgotten (later rvalid = stray err).
// STRUCTURE
// - wb_pkg: typedef enum logic [2:0] wb_src_e {WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PCIMM} with codes
//   above; localparam WB_SEL_ZERO=3'b111; typedef enum wb_state_e {IDLE, WAIT_MEM, DRAIN}.
// - One sub-module: wb_timeout_ctr (clear, enable, TIMEOUT_CYCLES param, expired flag).
// TESTING
// - Reset then back-to-back ALU rd=5, PC4 rd=1, IMM rd=0 -> sel 000/011/010 on 3 successive cycles,
//   we=1,1,0; retired_cnt_o=2.
// - MEM rd=7, rvalid 3 cycles later -> ready low 3 cycles; cycle after rvalid sel=001, rd=7, we=1.
// - MEM rd=4, flush 1 cycle later, rvalid 2 cycles after -> DRAIN, no we, no err, ready returns after rvalid.
// - MEM rd=4 with no response -> err_o pulse exactly TIMEOUT_CYCLES cycles after accept, we never 1.
// - Illegal code 100 and stray rvalid in IDLE -> err_o pulses, sel=111 for illegal, we=0.
// - Flush+rvalid same cycle in WAIT_MEM -> IDLE next cycle, no write; reset mid-WAIT_MEM -> later rvalid errs.

Source files
------------

// File: rtl/wb_select_ctrl_pkg.sv
// Shared types for the write-back select controller: source/select codes,
// sequencer states and the source-code legality check.
package wb_pkg;

  typedef enum logic [2:0] {
    WB_ALU   = 3'b000,
    WB_MEM   = 3'b001,
    WB_IMM   = 3'b010,
    WB_PC4   = 3'b011,
    WB_PCIMM = 3'b110
  } wb_src_e;

  // Unused mux leg that yields zero; steered to on an illegal source code.
  localparam logic [2:0] WB_SEL_ZERO = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    DRAIN
  } wb_state_e;

  function automatic logic wb_src_legal(input logic [2:0] code);
    case (code)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b110: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_select_ctrl_timeout.sv
// Load-response watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Saturates once expired so a stalled enable cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_select_ctrl.sv
// Write-back sequencer: takes decoded dest/source per instruction, waits for load
// data when needed, and drives the registered mux select, rd and write enable.
module wb_select_ctrl
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [2:0]       wb_src_i,
  input  logic [4:0]       rd_i,
  input  logic             mem_rvalid_i,
  input  logic             flush_i,
  output logic [2:0]       result_sel_o,
  output logic [4:0]       rd_o,
  output logic             reg_we_o,
  output logic             err_o,
  output logic [CNT_W-1:0] retired_cnt_o,
  output wb_state_e        dbg_state
);

  // Handshake: an instruction is taken on a rising edge where issue_valid_i and
  // issue_ready_o are both high; ready depends only on state and flush_i, never
  // on issue_valid_i.

  wb_state_e  state, state_n;
  logic [4:0] rd_lat, rd_lat_n;
  logic [2:0] sel_n;
  logic [4:0] rd_n;
  logic       we_n, err_n;
  logic       ctr_clear, ctr_expired;

  wb_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (state != IDLE),
    .expired (ctr_expired)
  );

  always_comb begin
    state_n       = state;
    rd_lat_n      = rd_lat;
    sel_n         = result_sel_o;
    rd_n          = rd_o;
    we_n          = 1'b0;
    err_n         = 1'b0;
    ctr_clear     = 1'b0;
    issue_ready_o = (state == IDLE) && !flush_i;
    case (state)
      IDLE: begin
        // Nothing is outstanding, so any response here is stray.
        if (mem_rvalid_i) err_n = 1'b1;
        if (issue_valid_i && issue_ready_o) begin
          if (!wb_src_legal(wb_src_i)) begin
            sel_n = WB_SEL_ZERO;
            err_n = 1'b1;
          end else if (wb_src_i == WB_MEM) begin
            rd_lat_n  = rd_i;
            ctr_clear = 1'b1;
            state_n   = WAIT_MEM;
          end else begin
            sel_n = wb_src_i;
            rd_n  = rd_i;
            we_n  = (rd_i != 5'd0);
          end
        end
      end
      WAIT_MEM: begin
        // Flush beats a same-cycle response; that response is consumed unwritten.
        if (flush_i) begin
          ctr_clear = 1'b1;
          state_n   = mem_rvalid_i ? IDLE : DRAIN;
        end else if (mem_rvalid_i) begin
          sel_n   = WB_MEM;
          rd_n    = rd_lat;
          we_n    = (rd_lat != 5'd0);
          state_n = IDLE;
        end else if (ctr_expired) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (mem_rvalid_i) begin
          state_n = IDLE;
        end else if (ctr_expired) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rd_lat        <= '0;
      result_sel_o  <= 3'b000;
      rd_o          <= '0;
      reg_we_o      <= 1'b0;
      err_o         <= 1'b0;
      retired_cnt_o <= '0;
    end else begin
      state         <= state_n;
      rd_lat        <= rd_lat_n;
      result_sel_o  <= sel_n;
      rd_o          <= rd_n;
      reg_we_o      <= we_n;
      err_o         <= err_n;
      retired_cnt_o <= retired_cnt_o + CNT_W'(we_n);
    end
  end

  assign dbg_state = state;

endmodule
